serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Multi-cycle signed/unsigned subtractor for the processor datapath. It computes `diff = a - b` on two's-complement operands, `CHUNK` bits per clock with a rippled borrow. It returns the difference plus borrow, overflow, zero and negative flags for the branch/compare logic. Operands enter through a valid/ready handshake and results leave through one, so the block can sit between the register-read stage and flag/writeback without a long combinational carry chain.

## Interface
- `WIDTH`, default 63: MSB index of the operands, so data width is `WIDTH+1` bits.
- `CHUNK`, default 16: bits processed per cycle. `(WIDTH+1) % CHUNK == 0` is required, and the block fails elaboration otherwise.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  operands `a`, `b` present.
- `in_ready`  out  1  block can accept operands.
- `a`  in  `WIDTH+1`  minuend, two's complement.
- `b`  in  `WIDTH+1`  subtrahend, two's complement.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer takes the result.
- `diff`  out  `WIDTH+1`  `a - b` modulo 2^(WIDTH+1).
- `borrow`  out  1  unsigned `a < b`.
- `overflow`  out  1  signed overflow.
- `zero`  out  1  `diff == 0`.
- `negative`  out  1  `diff[WIDTH]`.

## Operation
- `NUM_CHUNKS = (WIDTH+1)/CHUNK`.
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - `in_ready = 1`, `out_valid = 0`.
  - On `in_valid && in_ready`: latch `a` and `~b`, set `carry = 1`, clear the chunk counter, go to RUN.
- **RUN**
  - Each cycle, chunk `i` (LSB first) computes `{c, s} = a[i] + ~b[i] + carry`.
  - `s` is written into the `diff` register slice `i`, `carry <= c`, and the counter increments.
  - After chunk `NUM_CHUNKS-1` is written, go to DONE.
  - `in_ready = 0`.
- **DONE**
  - `out_valid = 1`; `diff` and all flags are held stable.
  - On `out_ready`, go to IDLE.
  - `in_ready = 0`: there is no overlap of operations and no skid buffer.
- **Flags**, registered and valid while `out_valid`:
  - `borrow = ~carry_final`.
  - `overflow = (a[WIDTH] != b[WIDTH]) && (diff[WIDTH] != a[WIDTH])`, using the latched operands.
  - `zero = ~|diff`.
  - `negative = diff[WIDTH]`.
- `in_valid` while `in_ready = 0` is ignored; the operands are not captured.
- **Reset**
  - Reset in any state, including mid-RUN, returns the FSM to IDLE and abandons any partial result.
  - After reset, `in_ready = 1`; `out_valid`, `diff` and all flags are 0.

## Timing
- Operands are accepted at edge T.
- RUN occupies edges T+1 … T+NUM_CHUNKS.
- `out_valid` is high after edge T+NUM_CHUNKS, which is 4 cycles for the defaults.
- Minimum initiation interval is `NUM_CHUNKS + 2` cycles: accept, RUN cycles, a DONE cycle with `out_ready` high, then return to IDLE.
- `out_ready` high on the first DONE cycle means `out_valid` lasts exactly one cycle.
- The `out_valid`/`out_ready` handshake is AXI-style: the result holds indefinitely under backpressure.
- All outputs are registered. There is no combinational path from the inputs to the outputs except through `in_ready`, which depends only on state.

## Structure
- Shared package `alu_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - the `NUM_CHUNKS` computation function;
  - the flag bit-position constants shared with the flags register.
- One sub-module, `sub_chunk`: a `CHUNK`-bit combinational add of `x + ~y + cin` producing `{cout, s}`. The top level holds the FSM, counter, operand/result registers and flags.

## Test plan
All scenarios use the defaults (`WIDTH=63`, `CHUNK=16`).
- **Simple subtract.** `a=10`, `b=3` → `diff=7`; `borrow`, `overflow`, `zero`, `negative` all 0; `out_valid` exactly 4 cycles after accept.
- **Negative result.** `a=3`, `b=10` → `diff=0xFFFF_FFFF_FFFF_FFF9`, `negative=1`, `borrow=1`, `overflow=0`.
- **Signed overflow.** `a=0x8000_0000_0000_0000`, `b=1` → `diff=0x7FFF_FFFF_FFFF_FFFF`, `overflow=1`, `negative=0`, `borrow=0`.
- **Equal operands and cross-chunk borrow.**
  - `a=b=0x1234_5678_9ABC_DEF0` → `diff=0`, `zero=1`, `borrow=0`.
  - Then `a=0x0001_0000_0000_0000`, `b=1` → `diff=0x0000_FFFF_FFFF_FFFF`, which shows the borrow rippling through three chunks.
- **Backpressure.** Hold `out_ready=0` for 5 cycles in DONE → `out_valid` stays 1, `diff` and flags stay stable, `in_ready` stays 0. A new `in_valid` during this window is not captured; the following accepted operation is unaffected.
- **Reset mid-operation.** Assert `rst` on the second RUN cycle → the next cycle has `in_ready=1`, `out_valid=0`, `diff=0`. A fresh `a=5`, `b=5` then yields `zero=1` after 4 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the serial subtractor: FSM states, chunk-count
// helper and bit positions inside the registered flags word.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int FLAG_BORROW   = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_ZERO     = 2;
  localparam int FLAG_NEGATIVE = 3;
  localparam int NUM_FLAGS     = 4;

  function automatic int num_chunks(input int width, input int chunk);
    return (width + 1) / chunk;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
// The master drives operands and out_ready; the slave returns result and flags.
interface serial_subtractor_if #(
  parameter int WIDTH = 63
);
  logic           in_valid;
  logic           in_ready;
  logic [WIDTH:0] a;
  logic [WIDTH:0] b;
  logic           out_valid;
  logic           out_ready;
  logic [WIDTH:0] diff;
  logic           borrow;
  logic           overflow;
  logic           zero;
  logic           negative;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, overflow, zero, negative
  );
endinterface

// File: rtl/sub_chunk.sv
// One CHUNK-bit slice of the subtractor: {o_cout, o_s} = i_x + ~i_y + i_cin.
module sub_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] i_x,
  input  logic [CHUNK-1:0] i_y,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_s,
  output logic             o_cout
);
  assign {o_cout, o_s} = {1'b0, i_x} + {1'b0, ~i_y} + {{CHUNK{1'b0}}, i_cin};
endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b, CHUNK bits per clock with a rippled borrow, returning
// difference plus borrow/overflow/zero/negative through valid/ready handshakes.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = 63,
  parameter int CHUNK = 16
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NUM_CHUNKS - 1);
  localparam logic [WIDTH:0]   CHUNK_MASK = (WIDTH + 1)'({CHUNK{1'b1}});

  generate
    if ((WIDTH + 1) % CHUNK != 0) begin : g_bad_chunk
      $error("serial_subtractor: WIDTH+1 must be a multiple of CHUNK");
    end
  endgenerate

  state_e               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [WIDTH:0]       r_a;
  logic [WIDTH:0]       r_nb;
  logic [WIDTH:0]       r_diff;
  logic                 r_carry;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_FLAGS-1:0] r_flags;

  int                   w_shift;
  logic [CHUNK-1:0]     w_a_chunk;
  logic [CHUNK-1:0]     w_b_chunk;
  logic [CHUNK-1:0]     w_s;
  logic                 w_cout;
  logic [WIDTH:0]       w_diff_next;
  logic [NUM_FLAGS-1:0] w_flags_next;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_shift   = int'(r_cnt) * CHUNK;
    w_a_chunk = CHUNK'(r_a >> w_shift);
    // The operand register holds ~b; sub_chunk re-inverts, so hand it b back.
    w_b_chunk = ~CHUNK'(r_nb >> w_shift);
    w_diff_next = (r_diff & ~(CHUNK_MASK << w_shift))
                | ((WIDTH + 1)'(w_s) << w_shift);
    w_flags_next                = '0;
    w_flags_next[FLAG_BORROW]   = ~w_cout;
    w_flags_next[FLAG_OVERFLOW] = (r_a[WIDTH] == r_nb[WIDTH])
                                && (w_diff_next[WIDTH] != r_a[WIDTH]);
    w_flags_next[FLAG_ZERO]     = ~|w_diff_next;
    w_flags_next[FLAG_NEGATIVE] = w_diff_next[WIDTH];
  end

  sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
    .i_x    (w_a_chunk),
    .i_y    (w_b_chunk),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset as well, since diff and flags must read 0 after reset.
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_nb        <= '0;
      r_diff      <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_nb       <= ~bus.b;
            r_carry    <= 1'b1;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_diff  <= w_diff_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_flags     <= w_flags_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.borrow    = r_flags[FLAG_BORROW];
  assign bus.overflow  = r_flags[FLAG_OVERFLOW];
  assign bus.zero      = r_flags[FLAG_ZERO];
  assign bus.negative  = r_flags[FLAG_NEGATIVE];

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, random operands,
// backpressure and mid-operation reset, with a result scoreboard queue.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(63)) bus ();

  serial_subtractor #(.WIDTH(63), .CHUNK(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [63:0] diff;
    logic        borrow;
    logic        overflow;
    logic        zero;
    logic        negative;
  } res_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    res_t        exp;
    int          hold;
  } vec_t;

  res_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b);
    res_t r;
    r.diff     = a - b;
    r.borrow   = (a < b);
    r.overflow = (a[63] != b[63]) && (r.diff[63] != a[63]);
    r.zero     = (r.diff == 64'd0);
    r.negative = r.diff[63];
    return r;
  endfunction

  function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b, input logic [63:0] d,
                              input logic bo, input logic ov, input logic ze, input logic ne,
                              input int hold);
    vec_t v;
    v.a = a; v.b = b; v.hold = hold;
    v.exp.diff = d; v.exp.borrow = bo; v.exp.overflow = ov; v.exp.zero = ze; v.exp.negative = ne;
    return v;
  endfunction

  task automatic check_result(input string tag, input res_t e);
    check({tag, ".diff"}, bus.diff, e.diff);
    check({tag, ".flags(bo,ov,ze,ne)"},
          {60'd0, bus.borrow, bus.overflow, bus.zero, bus.negative},
          {60'd0, e.borrow, e.overflow, e.zero, e.negative});
  endtask

  // Called one time unit after a rising edge with the DUT in IDLE.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input res_t e, input int hold);
    int   cycles;
    res_t got;
    check({tag, ".in_ready_idle"}, bus.in_ready, 1);
    bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      if (cycles == 1) check({tag, ".in_ready_run"}, bus.in_ready, 0);
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, ".latency"}, 64'(cycles), 64'd4);
    got = sb_q.pop_front();
    if (!bus.out_valid) return;
    for (int i = 0; i < hold; i++) begin
      // Stray operands while busy must be ignored.
      bus.in_valid = 1'b1; bus.a = ~a; bus.b = 64'h55;
      check_result({tag, ".held"}, got);
      check({tag, ".held.out_valid"}, bus.out_valid, 1);
      check({tag, ".held.in_ready"}, bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_result(tag, got);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, bus.out_valid, 0);
    check({tag, ".in_ready_back"}, bus.in_ready, 1);
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = mk(64'd10, 64'd3, 64'd7, 0, 0, 0, 0, 0);
    vecs[1] = mk(64'd3, 64'd10, 64'hFFFF_FFFF_FFFF_FFF9, 1, 0, 0, 1, 5);
    vecs[2] = mk(64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 0);
    vecs[3] = mk(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 0, 0, 1, 0, 0);
    vecs[4] = mk(64'h0001_0000_0000_0000, 64'd1, 64'h0000_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0);
    vecs[5] = mk(64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 1, 0);
    vecs[6] = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 1, 0, 1, 0);

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", bus.in_ready, 1);
    check("reset.out_valid", bus.out_valid, 0);
    check_result("reset", '0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);

    for (int i = 0; i < 4; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      do_op($sformatf("rand%0d", i), ra, rb, model(ra, rb), i);
    end

    // Reset during the second RUN cycle abandons the partial result.
    bus.a = 64'hFFFF_0000_1234_5678; bus.b = 64'd1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst.in_ready", bus.in_ready, 1);
    check("midrst.out_valid", bus.out_valid, 0);
    check_result("midrst", '0);
    do_op("after_rst", 64'd5, 64'd5, model(64'd5, 64'd5), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1);
  end

endmodule
